pll_reconfig_ctrl: RTL and testbench

//  Sequencer driving a PLL dynamic-reconfiguration port (mdopc/mdainc/mdwdi/mdrdo) from a

---
 rtl/pll_reconf_pkg.sv | 30 +++
 rtl/pll_lock_monitor.sv | 48 ++++
 rtl/pll_reconfig_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_pll_reconfig_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_reconf_pkg.sv
// Shared types and constants for the PLL dynamic-reconfiguration sequencer.
package pll_reconf_pkg;

  // Sequencer states. RB_ADDR/READ/RB_WAIT are only reachable in readback builds.
  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_RST       = 4'd1,
    ST_SET_ADDR  = 4'd2,
    ST_WRITE     = 4'd3,
    ST_RB_ADDR   = 4'd4,
    ST_READ      = 4'd5,
    ST_RB_WAIT   = 4'd6,
    ST_RELEASE   = 4'd7,
    ST_WAIT_LOCK = 4'd8,
    ST_DONE      = 4'd9,
    ST_ERR       = 4'd10
  } state_e;

  // Reconfiguration port opcodes.
  localparam logic [1:0] MDOPC_NOP     = 2'b00;
  localparam logic [1:0] MDOPC_WRITE   = 2'b01;
  localparam logic [1:0] MDOPC_READ    = 2'b10;
  localparam logic [1:0] MDOPC_SETADDR = 2'b11;

  // Index width for n entries, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pll_lock_monitor.sv
// Lock qualification: counts consecutive lock cycles and total cycles while enabled.
// locked_o fires on the cycle the stable count is reached; timeout_o on the cycle the
// budget expires. Both counters clear whenever en_i is low.
module pll_lock_monitor #(
  parameter int LOCK_STABLE  = 64,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  input  logic lock_i,
  output logic locked_o,
  output logic timeout_o
);

  localparam int STB_W = $clog2(LOCK_STABLE + 1);
  localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);

  logic [STB_W-1:0] stb_q, stb_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Next counts: stable count restarts on any lock drop, timeout count free-runs.
  always_comb begin
    stb_d = '0;
    tmo_d = '0;
    if (en_i) begin
      stb_d = lock_i ? (stb_q + 1'b1) : '0;
      tmo_d = tmo_q + 1'b1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stb_q <= '0;
      tmo_q <= '0;
    end else begin
      stb_q <= stb_d;
      tmo_q <= tmo_d;
    end
  end

  assign locked_o  = en_i & lock_i & (stb_q == STB_LAST);
  assign timeout_o = en_i & (tmo_q == TMO_LAST);

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// PLL dynamic-reconfiguration sequencer: holds the PLL in reset, streams one divider
// profile from a writable table onto the mdopc/mdainc/mdwdi port, releases reset and
// qualifies lock. Optional readback verify is enabled by PLL_RECONF_READBACK_EN.
// Handshake: a request transfers on the cycle req_valid && req_ready; req_ready is high
// only in IDLE, so requests seen while busy are simply ignored (no queueing).
module pll_reconfig_ctrl
  import pll_reconf_pkg::*;
#(
  parameter int         NUM_PROFILES = 4,
  parameter int         NUM_REGS     = 8,
  parameter logic [7:0] BASE_ADDR    = 8'h00,
  parameter int         RST_CYCLES   = 16,
  parameter int         LOCK_STABLE  = 64,
  parameter int         LOCK_TIMEOUT = 65535,
  localparam int        PROF_W       = clog2_min1(NUM_PROFILES),
  localparam int        IDX_W        = clog2_min1(NUM_REGS)
) (
  input  logic              mdclk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [PROF_W-1:0] cfg_prof,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [7:0]        cfg_data,
  input  logic              req_valid,
  input  logic [PROF_W-1:0] req_prof,
  output logic              req_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [PROF_W-1:0] cur_prof,
  output logic              pll_reset,
  input  logic              pll_lock,
  output logic [1:0]        mdopc,
  output logic              mdainc,
  output logic [7:0]        mdwdi,
  input  logic [7:0]        mdrdo,
  output logic [3:0]        dbg_state
);

  localparam int CNT_MAX = (RST_CYCLES > NUM_REGS) ? RST_CYCLES : NUM_REGS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]  RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  REG_LAST = CNT_W'(NUM_REGS - 1);
  localparam logic [PROF_W:0]   PROF_LIM = (PROF_W + 1)'(NUM_PROFILES);
  localparam logic [IDX_W:0]    IDX_LIM  = (IDX_W + 1)'(NUM_REGS);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [PROF_W-1:0] prof_q;
  logic [PROF_W-1:0] cur_prof_q;
  logic [7:0]        tbl_q [NUM_PROFILES][NUM_REGS];
  logic [7:0]        wr_byte;
  logic              req_bad;
  logic              locked;
  logic              timeout;
  logic              rb_fail;

  assign req_bad = ({1'b0, req_prof} >= PROF_LIM);
  assign wr_byte = tbl_q[prof_q][cnt_q[IDX_W-1:0]];

  // Profile table: single write port, writes dropped while a sequence is running.
  always_ff @(posedge mdclk) begin
    if (cfg_we && !busy && ({1'b0, cfg_prof} < PROF_LIM) && ({1'b0, cfg_idx} < IDX_LIM))
      tbl_q[cfg_prof][cfg_idx] <= cfg_data;
  end

  pll_lock_monitor #(
    .LOCK_STABLE (LOCK_STABLE),
    .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) u_lock_mon (
    .clk_i    (mdclk),
    .reset_i  (reset),
    .en_i     (state_q == ST_WAIT_LOCK),
    .lock_i   (pll_lock),
    .locked_o (locked),
    .timeout_o(timeout)
  );

`ifdef PLL_RECONF_READBACK_EN
  // Readback data arrives one cycle after each READ, so compare against a delayed index.
  logic             chk_vld_q;
  logic [IDX_W-1:0] chk_idx_q;
  logic             mm_q;
  logic             mm_now;

  assign mm_now  = chk_vld_q && (mdrdo != tbl_q[prof_q][chk_idx_q]);
  assign rb_fail = mm_q | mm_now;

  // Readback compare pipeline and sticky mismatch flag (cleared at RB_ADDR).
  always_ff @(posedge mdclk) begin
    if (reset) begin
      chk_vld_q <= 1'b0;
      chk_idx_q <= '0;
      mm_q      <= 1'b0;
    end else begin
      chk_vld_q <= (state_q == ST_READ);
      chk_idx_q <= cnt_q[IDX_W-1:0];
      if (state_q == ST_RB_ADDR) mm_q <= 1'b0;
      else if (mm_now)           mm_q <= 1'b1;
    end
  end
`else
  logic unused_rdo;
  assign unused_rdo = ^mdrdo;
  assign rb_fail    = 1'b0;
`endif

  // State register.
  always_ff @(posedge mdclk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Datapath: per-state cycle counter, latched profile, last applied profile.
  always_ff @(posedge mdclk) begin
    if (reset) begin
      cnt_q      <= '0;
      prof_q     <= '0;
      cur_prof_q <= '0;
    end else begin
      cnt_q <= (state_d != state_q) ? '0 : (cnt_q + 1'b1);
      if (state_q == ST_IDLE && req_valid) prof_q     <= req_prof;
      if (state_q == ST_DONE)              cur_prof_q <= prof_q;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (req_valid) state_d = req_bad ? ST_ERR : ST_RST;
      ST_RST:       if (cnt_q == RST_LAST) state_d = ST_SET_ADDR;
      ST_SET_ADDR:  state_d = ST_WRITE;
`ifdef PLL_RECONF_READBACK_EN
      ST_WRITE:     if (cnt_q == REG_LAST) state_d = ST_RB_ADDR;
      ST_RB_ADDR:   state_d = ST_READ;
      ST_READ:      if (cnt_q == REG_LAST) state_d = ST_RB_WAIT;
      ST_RB_WAIT:   state_d = rb_fail ? ST_ERR : ST_RELEASE;
`else
      ST_WRITE:     if (cnt_q == REG_LAST) state_d = ST_RELEASE;
`endif
      ST_RELEASE:   state_d = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        // A stable lock on the final timeout cycle still counts as success.
        if (locked)       state_d = ST_DONE;
        else if (timeout) state_d = ST_ERR;
      end
      ST_DONE:      state_d = ST_IDLE;
      ST_ERR:       state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Output decode from current state.
  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    pll_reset = 1'b0;
    mdopc     = MDOPC_NOP;
    mdainc    = 1'b0;
    mdwdi     = 8'h00;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      ST_RST:      pll_reset = 1'b1;
      ST_SET_ADDR, ST_RB_ADDR: begin
        pll_reset = 1'b1;
        mdopc     = MDOPC_SETADDR;
        mdwdi     = BASE_ADDR;
      end
      ST_WRITE: begin
        pll_reset = 1'b1;
        mdopc     = MDOPC_WRITE;
        mdainc    = 1'b1;
        mdwdi     = wr_byte;
      end
      ST_READ: begin
        pll_reset = 1'b1;
        mdopc     = MDOPC_READ;
        mdainc    = 1'b1;
      end
      ST_RB_WAIT:  pll_reset = 1'b1;
      ST_DONE:     done      = 1'b1;
      ST_ERR:      err       = 1'b1;
      default:     ;
    endcase
  end

  assign cur_prof  = cur_prof_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed bench for pll_reconfig_ctrl. Port traffic is checked against an expected
// queue filled when each request is issued; a small PLL register model answers READs.
// Builds with or without PLL_RECONF_READBACK_EN.
module tb_pll_reconfig_ctrl;
  import pll_reconf_pkg::*;

  localparam int         NP   = 5;
  localparam int         NR   = 8;
  localparam int         RSTC = 16;
  localparam int         STB  = 64;
  localparam int         TMO  = 300;
  localparam logic [7:0] BASE = 8'h00;
  localparam int         PW   = 3;
  localparam int         IW   = 3;
`ifdef PLL_RECONF_READBACK_EN
  localparam int RBX = NR + 2;
`else
  localparam int RBX = 0;
`endif
  // First WAIT_LOCK cycle, counting the accept edge as cycle 0.
  localparam int W0 = RSTC + 1 + NR + RBX + 1 + 1;

  logic          mdclk = 1'b0;
  logic          reset;
  logic          cfg_we;
  logic [PW-1:0] cfg_prof;
  logic [IW-1:0] cfg_idx;
  logic [7:0]    cfg_data;
  logic          req_valid;
  logic [PW-1:0] req_prof;
  logic          req_ready, busy, done, err;
  logic [PW-1:0] cur_prof;
  logic          pll_reset;
  logic          pll_lock;
  logic [1:0]    mdopc;
  logic          mdainc;
  logic [7:0]    mdwdi;
  logic [7:0]    mdrdo;
  logic [3:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];
  logic [10:0] obs_t, exp_t;
  logic [7:0]  tbl_m [NP][NR];
  bit          mon_en  = 1'b0;
  bit          corrupt = 1'b0;
  logic [7:0]  pll_mem [256];
  logic [7:0]  pll_addr;

  pll_reconfig_ctrl #(
    .NUM_PROFILES(NP), .NUM_REGS(NR), .BASE_ADDR(BASE),
    .RST_CYCLES(RSTC), .LOCK_STABLE(STB), .LOCK_TIMEOUT(TMO)
  ) dut (
    .mdclk(mdclk), .reset(reset), .cfg_we(cfg_we), .cfg_prof(cfg_prof),
    .cfg_idx(cfg_idx), .cfg_data(cfg_data), .req_valid(req_valid),
    .req_prof(req_prof), .req_ready(req_ready), .busy(busy), .done(done),
    .err(err), .cur_prof(cur_prof), .pll_reset(pll_reset), .pll_lock(pll_lock),
    .mdopc(mdopc), .mdainc(mdainc), .mdwdi(mdwdi), .mdrdo(mdrdo),
    .dbg_state(dbg_state)
  );

  // Clock.
  always #5 mdclk = ~mdclk;

  // PLL reconfiguration register model; optionally corrupts register BASE+3 on read.
  always @(posedge mdclk) begin
    case (mdopc)
      MDOPC_SETADDR: pll_addr <= mdwdi;
      MDOPC_WRITE: begin
        pll_mem[pll_addr] <= mdwdi;
        if (mdainc) pll_addr <= pll_addr + 8'd1;
      end
      MDOPC_READ: begin
        mdrdo <= (corrupt && pll_addr == BASE + 8'd3) ? ~pll_mem[pll_addr] : pll_mem[pll_addr];
        if (mdainc) pll_addr <= pll_addr + 8'd1;
      end
      default: ;
    endcase
  end

  // Scoreboard: every non-NOP port cycle must match the head of the expected queue.
  always @(negedge mdclk) begin
    if (mon_en && mdopc !== MDOPC_NOP) begin
      obs_t = {mdopc, mdainc, mdwdi};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL port_txn obs=%0h exp=none", obs_t);
      end else begin
        exp_t = exp_q.pop_front();
        assert (obs_t === exp_t) else begin
          errors++;
          $error("FAIL port_txn obs=%0h exp=%0h", obs_t, exp_t);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge mdclk);
    #1;
  endtask

  task automatic write_cfg(input int p, input int i, input logic [7:0] d);
    cfg_we   = 1'b1;
    cfg_prof = PW'(p);
    cfg_idx  = IW'(i);
    cfg_data = d;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic push_seq(input int p);
    exp_q.push_back({MDOPC_SETADDR, 1'b0, BASE});
    for (int i = 0; i < NR; i++) exp_q.push_back({MDOPC_WRITE, 1'b1, tbl_m[p][i]});
`ifdef PLL_RECONF_READBACK_EN
    exp_q.push_back({MDOPC_SETADDR, 1'b0, BASE});
    for (int i = 0; i < NR; i++) exp_q.push_back({MDOPC_READ, 1'b1, 8'h00});
`endif
  endtask

  task automatic issue(input logic [PW-1:0] p);
    req_prof  = p;
    req_valid = 1'b1;
    chk("req_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_prof = '0; cfg_idx = '0; cfg_data = '0;
    req_valid = 1'b0; req_prof = '0; pll_lock = 1'b0;
    tick(); tick();
    // Reset state.
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_pll_reset", pll_reset, 0);
    chk("rst_mdopc", mdopc, 0);
    chk("rst_mdainc", mdainc, 0);
    chk("rst_mdwdi", mdwdi, 0);
    chk("rst_cur_prof", cur_prof, 0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Table load: profile 1 gets 0x10..0x17, others random.
    for (int p = 0; p < NP; p++)
      for (int i = 0; i < NR; i++) begin
        tbl_m[p][i] = (p == 1) ? 8'(8'h10 + i) : 8'($urandom_range(0, 255));
        write_cfg(p, i, tbl_m[p][i]);
      end

    // Profile 1, lock rises 5 cycles into WAIT_LOCK.
    push_seq(1);
    issue(3'd1);
    for (int k = 1; k <= W0 + 5 + STB; k++) begin
      pll_lock = (k >= W0 + 5);
      chk("t1_busy", busy, 1);
      chk("t1_pll_reset", pll_reset, (k <= W0 - 2));
      chk("t1_done", done, (k == W0 + 5 + STB));
      chk("t1_err", err, 0);
      tick();
    end
    pll_lock = 1'b0;
    chk("t1_done_end", done, 0);
    chk("t1_cur_prof", cur_prof, 1);
    chk("t1_idle", dbg_state, ST_IDLE);

    // Out-of-range profile: err one cycle after accept, no PLL or port activity.
    issue(3'd5);
    chk("bad_err", err, 1);
    chk("bad_pll_reset", pll_reset, 0);
    chk("bad_mdopc", mdopc, 0);
    tick();
    chk("bad_err_end", err, 0);
    chk("bad_pll_reset2", pll_reset, 0);
    chk("bad_idle", dbg_state, ST_IDLE);
    chk("bad_cur_prof", cur_prof, 1);

    // Lock never asserts: err exactly TMO cycles into WAIT_LOCK.
    push_seq(2);
    issue(3'd2);
    for (int k = 1; k <= W0 + TMO; k++) begin
      chk("tmo_err", err, (k == W0 + TMO));
      chk("tmo_done", done, 0);
      tick();
    end
    chk("tmo_err_end", err, 0);
    chk("tmo_cur_prof", cur_prof, 1);

    // Lock drops at stable count 63; done 64 cycles after re-assert.
    // Also: a request and a table write while busy must both be ignored.
    push_seq(0);
    issue(3'd0);
    for (int k = 1; k <= W0 + 64 + STB; k++) begin
      pll_lock = (k >= W0) && (k != W0 + 63);
      if (k == W0 + 10) begin
        req_valid = 1'b1; req_prof = 3'd2;
        cfg_we = 1'b1; cfg_prof = 3'd1; cfg_idx = 3'd0; cfg_data = 8'hFF;
        chk("glitch_ready_busy", req_ready, 0);
      end else begin
        req_valid = 1'b0;
        cfg_we    = 1'b0;
      end
      chk("glitch_done", done, (k == W0 + 64 + STB));
      chk("glitch_err", err, 0);
      tick();
    end
    pll_lock = 1'b0;
    chk("glitch_cur_prof", cur_prof, 0);
    tick();
    chk("glitch_no_requeue", busy, 0);

    // Reset mid-WRITE: third byte on the port, then abort to IDLE with no pulses.
    exp_q.push_back({MDOPC_SETADDR, 1'b0, BASE});
    for (int i = 0; i < 3; i++) exp_q.push_back({MDOPC_WRITE, 1'b1, tbl_m[1][i]});
    issue(3'd1);
    for (int k = 1; k < RSTC + 4; k++) begin
      chk("abort_pll_reset", pll_reset, 1);
      tick();
    end
    reset = 1'b1;
    chk("abort_in_write", mdopc, MDOPC_WRITE);
    tick();
    chk("abort_idle", dbg_state, ST_IDLE);
    chk("abort_pll_reset0", pll_reset, 0);
    chk("abort_mdopc", mdopc, 0);
    chk("abort_mdainc", mdainc, 0);
    chk("abort_done", done, 0);
    chk("abort_err", err, 0);
    chk("abort_cur_prof", cur_prof, 0);
    tick();
    chk("abort_done2", done, 0);
    chk("abort_err2", err, 0);
    reset = 1'b0;
    tick();

`ifdef PLL_RECONF_READBACK_EN
    // Readback with byte 3 corrupted: err right after the last compare.
    corrupt = 1'b1;
    push_seq(2);
    issue(3'd2);
    for (int k = 1; k <= W0 - 1; k++) begin
      chk("rb_bad_err", err, (k == W0 - 1));
      chk("rb_bad_done", done, 0);
      tick();
    end
    chk("rb_bad_cur_prof", cur_prof, 0);
    corrupt = 1'b0;

    // Clean readback: done as normal.
    push_seq(2);
    issue(3'd2);
    for (int k = 1; k <= W0 + STB; k++) begin
      pll_lock = (k >= W0);
      chk("rb_ok_done", done, (k == W0 + STB));
      chk("rb_ok_err", err, 0);
      tick();
    end
    pll_lock = 1'b0;
    chk("rb_ok_cur_prof", cur_prof, 2);
`endif

    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
